// File: rtl/screen_scan_pkg.sv
// Shared constants, state encoding and address helper for the CHIP-8 screen scanner.
package screen_scan_pkg;

  localparam int unsigned FB_BASE       = 'h100;
  localparam int unsigned FB_W          = 64;
  localparam int unsigned FB_H          = 32;
  localparam int unsigned FB_ROW_BYTES  = FB_W / 8;
  localparam int unsigned DISP_W        = 128;
  localparam int unsigned DISP_PAGES    = 8;
  localparam int unsigned ADDR_W        = 12;
  localparam int unsigned DATA_W        = 8;
  // Each display page covers 4 framebuffer rows at 2x vertical scale.
  localparam int unsigned ROWS_PER_PAGE = FB_H / DISP_PAGES;
  // One framebuffer byte (8 pixels) becomes 16 display columns.
  localparam int unsigned GROUP_COLS    = DISP_W / FB_ROW_BYTES;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FETCH = 2'd1,
    ST_EMIT  = 2'd2,
    ST_DONE  = 2'd3
  } scan_state_e;

  // Byte address of framebuffer row (4*page + row), byte column bx.
  function automatic logic [ADDR_W-1:0] fb_addr(input logic [ADDR_W-1:0] base,
                                                 input logic [2:0]        page,
                                                 input logic [1:0]        row,
                                                 input logic [2:0]        bx);
    return base + ADDR_W'({page, row, bx});
  endfunction

endpackage

// File: rtl/screen_scan_fb_page_packer.sv
// fb_page_packer: 4-row byte buffer plus the 2x-scaled page-byte former.
// Ports:
//   clk, reset_n : clock, async active-low reset
//   i_load[3:0]  : per-row load strobe, captures i_data into that row
//   i_data       : framebuffer byte from memory
//   i_x          : pixel index within the 8-pixel group (column-in-group / 2)
//   o_byte_c     : combinational page byte, LSB = top pixel
module screen_scan_fb_page_packer
  import screen_scan_pkg::*;
(
  input  logic              clk,
  input  logic              reset_n,
  input  logic [3:0]        i_load,
  input  logic [DATA_W-1:0] i_data,
  input  logic [2:0]        i_x,
  output logic [DATA_W-1:0] o_byte_c
);

  logic [3:0][DATA_W-1:0] r_buf;
  logic [3:0][DATA_W-1:0] w_row;
  logic [2:0]             w_bit;

  // Row buffer, one byte per framebuffer row of the current page.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_buf <= '0;
    end else begin
      if (i_load[0]) r_buf[0] <= i_data;
      if (i_load[1]) r_buf[1] <= i_data;
      if (i_load[2]) r_buf[2] <= i_data;
      if (i_load[3]) r_buf[3] <= i_data;
    end
  end

  // Write-through view so the first byte of a group can be formed in the
  // same cycle the last row arrives.
  always_comb begin
    w_row = r_buf;
    if (i_load[0]) w_row[0] = i_data;
    if (i_load[1]) w_row[1] = i_data;
    if (i_load[2]) w_row[2] = i_data;
    if (i_load[3]) w_row[3] = i_data;
    // Pixel x%8 sits at bit 7-(x%8); each row fills two output bits.
    w_bit    = ~i_x;
    o_byte_c = {w_row[3][w_bit], w_row[3][w_bit],
                w_row[2][w_bit], w_row[2][w_bit],
                w_row[1][w_bit], w_row[1][w_bit],
                w_row[0][w_bit], w_row[0][w_bit]};
  end

endmodule

// File: rtl/screen_scan.sv
// screen_scan: reads the 64x32 CHIP-8 framebuffer and streams it as a
// 128x64 SSD1306-style page image (8 pages x 128 columns) at 2x scale.
// Ports:
//   clk, reset_n          : clock, async active-low reset
//   start / busy / done   : frame request, frame in progress, end-of-frame pulse
//   mem_addr/mem_rd/mem_data : read port, data valid one cycle after mem_rd
//   out_data/out_valid/out_ready/out_first : page-byte stream, first = page 0 col 0
module screen_scan
  import screen_scan_pkg::*;
#(
  parameter int unsigned FB_BASE = screen_scan_pkg::FB_BASE
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              start,
  output logic              busy,
  output logic              done,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_rd,
  input  logic [DATA_W-1:0] mem_data,
  output logic [DATA_W-1:0] out_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              out_first
);

  localparam logic [ADDR_W-1:0] BASE_A  = ADDR_W'(FB_BASE);
  localparam logic [1:0]        R_LAST  = 2'(ROWS_PER_PAGE - 1);
  localparam logic [3:0]        C_LAST  = 4'(GROUP_COLS - 1);
  localparam logic [2:0]        BX_LAST = 3'(FB_ROW_BYTES - 1);
  localparam logic [2:0]        P_LAST  = 3'(DISP_PAGES - 1);

  scan_state_e       r_state, w_state_nxt;
  logic [2:0]        r_p, w_p_nxt;
  logic [2:0]        r_bx, w_bx_nxt;
  logic [3:0]        r_col, w_col_nxt;
  logic [1:0]        r_r, w_r_nxt;
  logic              r_cap_en, w_cap_en_nxt;
  logic [1:0]        r_cap_idx, w_cap_idx_nxt;
  logic              r_busy, w_busy_nxt;
  logic              r_done, w_done_nxt;
  logic              r_mem_rd, w_mem_rd_nxt;
  logic [ADDR_W-1:0] r_mem_addr, w_mem_addr_nxt;
  logic [DATA_W-1:0] r_out_data, w_out_data_nxt;
  logic              r_out_valid, w_out_valid_nxt;
  logic              r_out_first, w_out_first_nxt;

  logic [3:0]        w_load;
  logic [2:0]        w_pack_x;
  logic [DATA_W-1:0] w_pack_byte;
  logic              w_accept;

  assign busy      = r_busy;
  assign done      = r_done;
  assign mem_addr  = r_mem_addr;
  assign mem_rd    = r_mem_rd;
  assign out_data  = r_out_data;
  assign out_valid = r_out_valid;
  assign out_first = r_out_first;

  assign w_accept = r_out_valid && out_ready;
  // Read data lands one cycle after its strobe; capture into that row.
  assign w_load   = r_cap_en ? 4'(4'd1 << r_cap_idx) : 4'd0;
  // Packer looks at the column that will be presented next.
  assign w_pack_x = (r_state == ST_EMIT) ? 3'((r_col + 4'd1) >> 1) : 3'd0;

  screen_scan_fb_page_packer u_fb_page_packer (
    .clk      (clk),
    .reset_n  (reset_n),
    .i_load   (w_load),
    .i_data   (mem_data),
    .i_x      (w_pack_x),
    .o_byte_c (w_pack_byte)
  );

  // State and registered outputs.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state     <= ST_IDLE;
      r_p         <= '0;
      r_bx        <= '0;
      r_col       <= '0;
      r_r         <= '0;
      r_cap_en    <= 1'b0;
      r_cap_idx   <= '0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
      r_mem_rd    <= 1'b0;
      r_mem_addr  <= '0;
      r_out_data  <= '0;
      r_out_valid <= 1'b0;
      r_out_first <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_p         <= w_p_nxt;
      r_bx        <= w_bx_nxt;
      r_col       <= w_col_nxt;
      r_r         <= w_r_nxt;
      r_cap_en    <= w_cap_en_nxt;
      r_cap_idx   <= w_cap_idx_nxt;
      r_busy      <= w_busy_nxt;
      r_done      <= w_done_nxt;
      r_mem_rd    <= w_mem_rd_nxt;
      r_mem_addr  <= w_mem_addr_nxt;
      r_out_data  <= w_out_data_nxt;
      r_out_valid <= w_out_valid_nxt;
      r_out_first <= w_out_first_nxt;
    end
  end

  // Next-state and next-output logic.
  always_comb begin
    w_state_nxt     = r_state;
    w_p_nxt         = r_p;
    w_bx_nxt        = r_bx;
    w_col_nxt       = r_col;
    w_r_nxt         = r_r;
    w_cap_en_nxt    = r_mem_rd;
    w_cap_idx_nxt   = r_r;
    w_busy_nxt      = r_busy;
    w_done_nxt      = 1'b0;
    w_mem_rd_nxt    = 1'b0;
    w_mem_addr_nxt  = r_mem_addr;
    w_out_data_nxt  = r_out_data;
    w_out_valid_nxt = r_out_valid;
    w_out_first_nxt = r_out_first;

    case (r_state)
      ST_IDLE: begin
        if (start) begin
          w_state_nxt    = ST_FETCH;
          w_p_nxt        = '0;
          w_bx_nxt       = '0;
          w_r_nxt        = '0;
          w_busy_nxt     = 1'b1;
          w_mem_rd_nxt   = 1'b1;
          w_mem_addr_nxt = fb_addr(BASE_A, 3'd0, 2'd0, 3'd0);
        end
      end

      ST_FETCH: begin
        // Back-to-back reads for the remaining rows of this page.
        if (r_mem_rd && (r_r != R_LAST)) begin
          w_r_nxt        = r_r + 2'd1;
          w_mem_rd_nxt   = 1'b1;
          w_mem_addr_nxt = fb_addr(BASE_A, r_p, r_r + 2'd1, r_bx);
        end
        if (r_cap_en && (r_cap_idx == R_LAST)) begin
          w_state_nxt     = ST_EMIT;
          w_col_nxt       = '0;
          w_out_valid_nxt = 1'b1;
          w_out_data_nxt  = w_pack_byte;
          w_out_first_nxt = (r_p == 3'd0) && (r_bx == 3'd0);
        end
      end

      ST_EMIT: begin
        if (w_accept) begin
          w_out_first_nxt = 1'b0;
          if (r_col != C_LAST) begin
            w_col_nxt      = r_col + 4'd1;
            w_out_data_nxt = w_pack_byte;
          end else begin
            w_out_valid_nxt = 1'b0;
            if (r_bx != BX_LAST) begin
              w_state_nxt    = ST_FETCH;
              w_bx_nxt       = r_bx + 3'd1;
              w_r_nxt        = '0;
              w_mem_rd_nxt   = 1'b1;
              w_mem_addr_nxt = fb_addr(BASE_A, r_p, 2'd0, r_bx + 3'd1);
            end else if (r_p != P_LAST) begin
              w_state_nxt    = ST_FETCH;
              w_p_nxt        = r_p + 3'd1;
              w_bx_nxt       = '0;
              w_r_nxt        = '0;
              w_mem_rd_nxt   = 1'b1;
              w_mem_addr_nxt = fb_addr(BASE_A, r_p + 3'd1, 2'd0, 3'd0);
            end else begin
              w_state_nxt = ST_DONE;
              w_busy_nxt  = 1'b0;
              w_done_nxt  = 1'b1;
            end
          end
        end
      end

      ST_DONE: begin
        w_state_nxt = ST_IDLE;
      end

      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

endmodule
